// File: rtl/stm_segment_scheduler_if.sv
// -----------------------------------------------------------------------------
// stm_segment_scheduler_if
// Bundles the settings inputs and the index/segment outputs of the STM segment
// scheduler.
//   master : settings register block / update source (drives strobes and settings)
//   slave  : the scheduler itself
// Signals:
//   UPDATE, UPDATE_SETTINGS        one-cycle strobes
//   REQ_RD_SEGMENT, REP, TRANSITION_MODE, CYCLE_0/1, FREQ_DIV_0/1  settings
//   IDX, SEGMENT, IDX_VALID, STOPPED                               scheduler outputs
// -----------------------------------------------------------------------------
interface stm_segment_scheduler_if #(
    parameter int IDX_W = 16,
    parameter int DIV_W = 32
);
    logic             UPDATE;
    logic             UPDATE_SETTINGS;
    logic             REQ_RD_SEGMENT;
    logic [31:0]      REP;
    logic             TRANSITION_MODE;
    logic [IDX_W-1:0] CYCLE_0;
    logic [IDX_W-1:0] CYCLE_1;
    logic [DIV_W-1:0] FREQ_DIV_0;
    logic [DIV_W-1:0] FREQ_DIV_1;
    logic [IDX_W-1:0] IDX;
    logic             SEGMENT;
    logic             IDX_VALID;
    logic             STOPPED;

    modport master (
        output UPDATE, UPDATE_SETTINGS, REQ_RD_SEGMENT, REP, TRANSITION_MODE,
               CYCLE_0, CYCLE_1, FREQ_DIV_0, FREQ_DIV_1,
        input  IDX, SEGMENT, IDX_VALID, STOPPED
    );

    modport slave (
        input  UPDATE, UPDATE_SETTINGS, REQ_RD_SEGMENT, REP, TRANSITION_MODE,
               CYCLE_0, CYCLE_1, FREQ_DIV_0, FREQ_DIV_1,
        output IDX, SEGMENT, IDX_VALID, STOPPED
    );
endinterface

// File: rtl/stm_segment_scheduler.sv
// -----------------------------------------------------------------------------
// stm_segment_scheduler
// Decides which segment (0/1) and which sample index the STM datapath renders on
// each UPDATE strobe. Settings are captured into shadow registers on
// UPDATE_SETTINGS and applied at a switch, either on the next UPDATE
// (TRANSITION_MODE=0) or when the running segment wraps (TRANSITION_MODE=1).
// Each sample lasts FREQ_DIV UPDATEs, the index wraps at CYCLE, and a finite
// REP stops playback after REP+1 full cycles with IDX held at CYCLE.
//
// Ports:
//   CLK     system clock
//   RST_N   synchronous active-low reset
//   bus     stm_segment_scheduler_if.slave (strobes, settings, IDX/SEGMENT/
//           IDX_VALID/STOPPED)
//   DEBUG_LOOP_CNT, DEBUG_STATE  only when STM_SCHED_DEBUG_EN is defined
//
// Optional feature macro: STM_SCHED_DEBUG_EN
//   Adds DEBUG_LOOP_CNT[31:0] (live loop counter) and DEBUG_STATE[1:0]
//   (IDLE=0, RUN=1, WAIT_BOUNDARY=2, STOP=3).
// -----------------------------------------------------------------------------
module stm_segment_scheduler #(
    parameter int IDX_W = 16,
    parameter int DIV_W = 32
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    stm_segment_scheduler_if.slave  bus
`ifdef STM_SCHED_DEBUG_EN
    ,
    output logic [31:0]             DEBUG_LOOP_CNT,
    output logic [1:0]              DEBUG_STATE
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_STOP = 2'd3
    } state_t;

    localparam logic [31:0]      REP_INF = 32'hFFFF_FFFF;
    localparam logic [31:0]      LOOP_MAX = 32'hFFFF_FFFF;
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    // A divider of 0 behaves exactly like 1.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_ONE : d;
    endfunction

    state_t           state_q;
    logic [IDX_W-1:0] idx_q, cyc_q;
    logic [DIV_W-1:0] div_cnt_q, fdiv_q;
    logic [31:0]      loop_cnt_q, rep_q;
    logic             seg_q, vld_q, stopped_q;

    // Shadow copy of the most recent request
    logic             pend_q, sh_seg_q, sh_mode_q;
    logic [31:0]      sh_rep_q;
    logic [IDX_W-1:0] sh_cyc0_q, sh_cyc1_q;
    logic [DIV_W-1:0] sh_fdiv0_q, sh_fdiv1_q;

    logic             tick_d, wrap_d, stop_hit_d, sw_d;
    logic [DIV_W-1:0] div_cnt_d;
    logic [IDX_W-1:0] idx_d;
    logic [31:0]      loop_cnt_d;

    // Advance arithmetic for one UPDATE in RUN/WAIT_BOUNDARY.
    always_comb begin
        tick_d     = (div_cnt_q == (fdiv_q - DIV_ONE));
        wrap_d     = tick_d && (idx_q == cyc_q);
        div_cnt_d  = tick_d ? '0 : (div_cnt_q + DIV_ONE);
        idx_d      = idx_q;
        if (tick_d) begin
            idx_d = wrap_d ? '0 : (idx_q + IDX_ONE);
        end
        // Saturate so infinite playback never wraps the loop counter.
        loop_cnt_d = (wrap_d && (loop_cnt_q != LOOP_MAX)) ? (loop_cnt_q + 32'd1) : loop_cnt_q;
        // This wrap completes loop number REP+1.
        stop_hit_d = wrap_d && (rep_q != REP_INF) && (loop_cnt_q == rep_q);
        // IDLE and STOP switch on any pending request; RUN/WAIT honour the mode,
        // and a boundary switch takes precedence over stopping on that wrap.
        sw_d = bus.UPDATE && pend_q &&
               ((state_q == S_IDLE) || (state_q == S_STOP) || !sh_mode_q || wrap_d);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cyc_q      <= '0;
            div_cnt_q  <= '0;
            fdiv_q     <= '0;
            loop_cnt_q <= '0;
            rep_q      <= '0;
            seg_q      <= 1'b0;
            vld_q      <= 1'b0;
            stopped_q  <= 1'b0;
            pend_q     <= 1'b0;
            sh_seg_q   <= 1'b0;
            sh_mode_q  <= 1'b0;
            sh_rep_q   <= '0;
            sh_cyc0_q  <= '0;
            sh_cyc1_q  <= '0;
            sh_fdiv0_q <= '0;
            sh_fdiv1_q <= '0;
        end else begin
            vld_q <= bus.UPDATE && ((state_q != S_IDLE) || pend_q);

            if (sw_d) begin
                state_q    <= S_RUN;
                seg_q      <= sh_seg_q;
                idx_q      <= '0;
                div_cnt_q  <= '0;
                loop_cnt_q <= '0;
                rep_q      <= sh_rep_q;
                cyc_q      <= sh_seg_q ? sh_cyc1_q : sh_cyc0_q;
                fdiv_q     <= eff_div(sh_seg_q ? sh_fdiv1_q : sh_fdiv0_q);
                stopped_q  <= 1'b0;
            end else if (bus.UPDATE && ((state_q == S_RUN) || (state_q == S_WAIT))) begin
                div_cnt_q  <= div_cnt_d;
                loop_cnt_q <= loop_cnt_d;
                if (stop_hit_d) begin
                    // IDX stays at CYCLE while stopped.
                    state_q   <= S_STOP;
                    stopped_q <= 1'b1;
                end else begin
                    idx_q   <= idx_d;
                    // Only a boundary-mode request can survive an UPDATE unapplied.
                    state_q <= pend_q ? S_WAIT : S_RUN;
                end
            end

            // A request arriving with an UPDATE is seen from the next UPDATE on.
            if (bus.UPDATE_SETTINGS) begin
                pend_q     <= 1'b1;
                sh_seg_q   <= bus.REQ_RD_SEGMENT;
                sh_mode_q  <= bus.TRANSITION_MODE;
                sh_rep_q   <= bus.REP;
                sh_cyc0_q  <= bus.CYCLE_0;
                sh_cyc1_q  <= bus.CYCLE_1;
                sh_fdiv0_q <= bus.FREQ_DIV_0;
                sh_fdiv1_q <= bus.FREQ_DIV_1;
            end else if (sw_d) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign bus.IDX       = idx_q;
    assign bus.SEGMENT   = seg_q;
    assign bus.IDX_VALID = vld_q;
    assign bus.STOPPED   = stopped_q;

`ifdef STM_SCHED_DEBUG_EN
    assign DEBUG_LOOP_CNT = loop_cnt_q;
    assign DEBUG_STATE    = state_q;
`endif

endmodule

// File: tb/tb_stm_segment_scheduler.sv
module tb_stm_segment_scheduler;
    localparam int IDX_W = 16;
    localparam int DIV_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stm_segment_scheduler_if #(.IDX_W(IDX_W), .DIV_W(DIV_W)) bus ();

    stm_segment_scheduler #(.IDX_W(IDX_W), .DIV_W(DIV_W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        seg;
        logic        mode;
        logic [31:0] rep;
        logic [15:0] cyc0;
        logic [15:0] cyc1;
        logic [31:0] fd0;
        logic [31:0] fd1;
    } req_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position derived from the number of UPDATEs since the
    // last switch.
    bit              m_active, m_pend, m_seg;
    req_t            m_req;
    longint unsigned m_cyc, m_fdiv, m_rep, m_u;
    bit              e_valid, e_seg, e_stop;
    logic [15:0]     e_idx;

    function automatic bit m_stopped();
        if (!m_active || m_rep == 64'hFFFF_FFFF) return 1'b0;
        return (m_u / m_fdiv) >= (m_rep + 1) * (m_cyc + 1);
    endfunction

    function automatic bit m_wrap_at(longint unsigned u);
        return (u > 0) && (u % m_fdiv == 0) && (((u / m_fdiv) % (m_cyc + 1)) == 0);
    endfunction

    function automatic void m_switch();
        longint unsigned fd;
        m_active = 1'b1;
        m_seg    = m_req.seg;
        m_cyc    = m_req.seg ? m_req.cyc1 : m_req.cyc0;
        fd       = m_req.seg ? m_req.fd1 : m_req.fd0;
        m_fdiv   = (fd == 0) ? 1 : fd;
        m_rep    = m_req.rep;
        m_u      = 0;
        m_pend   = 1'b0;
    endfunction

    function automatic void m_edge(bit upd, bit set, req_t r);
        e_valid = upd && (m_active || m_pend);
        if (upd) begin
            if (!m_active) begin
                if (m_pend) m_switch();
            end else if (m_pend && (!m_req.mode || m_stopped() || m_wrap_at(m_u + 1))) begin
                m_switch();
            end else begin
                m_u++;
            end
        end
        if (set) begin
            m_req  = r;
            m_pend = 1'b1;
        end
        if (!m_active) begin
            e_idx = '0; e_seg = 1'b0; e_stop = 1'b0;
        end else begin
            e_stop = m_stopped();
            e_seg  = m_seg;
            e_idx  = e_stop ? 16'(m_cyc) : 16'((m_u / m_fdiv) % (m_cyc + 1));
        end
    endfunction

    function automatic void m_reset();
        m_active = 1'b0; m_pend = 1'b0; m_seg = 1'b0;
        m_cyc = 0; m_fdiv = 1; m_rep = 0; m_u = 0;
        e_valid = 1'b0; e_idx = '0; e_seg = 1'b0; e_stop = 1'b0;
    endfunction

    function automatic req_t mk_req(bit seg, bit mode, logic [31:0] rep,
                                    logic [15:0] c0, logic [31:0] f0,
                                    logic [15:0] c1, logic [31:0] f1);
        req_t r;
        r.seg = seg; r.mode = mode; r.rep = rep;
        r.cyc0 = c0; r.fd0 = f0; r.cyc1 = c1; r.fd1 = f1;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.seg  = $urandom_range(0, 1);
        r.mode = $urandom_range(0, 1);
        case ($urandom_range(0, 3))
            0: r.rep = 32'd0;
            1: r.rep = 32'd1;
            2: r.rep = 32'd2;
            default: r.rep = 32'hFFFF_FFFF;
        endcase
        r.cyc0 = 16'($urandom_range(0, 5));
        r.cyc1 = 16'($urandom_range(0, 5));
        r.fd0  = $urandom_range(0, 3);
        r.fd1  = $urandom_range(0, 3);
        return r;
    endfunction

    // One clock: drive strobes/settings, advance the model at the edge, and
    // leave the bench 1 time unit after the edge for sampling.
    task automatic step(input bit upd, input bit set, input req_t r);
        bus.UPDATE          = upd;
        bus.UPDATE_SETTINGS = set;
        bus.REQ_RD_SEGMENT  = r.seg;
        bus.TRANSITION_MODE = r.mode;
        bus.REP             = r.rep;
        bus.CYCLE_0         = r.cyc0;
        bus.CYCLE_1         = r.cyc1;
        bus.FREQ_DIV_0      = r.fd0;
        bus.FREQ_DIV_1      = r.fd1;
        @(posedge clk);
        m_edge(upd, set, r);
        #1;
        bus.UPDATE          = 1'b0;
        bus.UPDATE_SETTINGS = 1'b0;
    endtask

    task automatic do_reset(input bit upd);
        rst_n      = 1'b0;
        bus.UPDATE = upd;
        @(posedge clk);
        m_reset();
        #1;
        rst_n      = 1'b1;
        bus.UPDATE = 1'b0;
    endtask

    task automatic test_reset();
        req_t junk;
        junk = rand_req();
        do_reset(1'b0);
        n_tests++;
        if (bus.IDX !== 16'd0 || bus.SEGMENT !== 1'b0 || bus.IDX_VALID !== 1'b0 || bus.STOPPED !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: idx/seg/valid/stop got %0d/%b/%b/%b want 0/0/0/0",
                     bus.IDX, bus.SEGMENT, bus.IDX_VALID, bus.STOPPED);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, junk);
            n_tests++;
            if (bus.IDX_VALID !== 1'b0 || bus.IDX !== 16'd0 || bus.SEGMENT !== 1'b0 || bus.STOPPED !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_update %0d: valid/idx/seg/stop got %b/%0d/%b/%b want 0/0/0/0",
                         i, bus.IDX_VALID, bus.IDX, bus.SEGMENT, bus.STOPPED);
            end
        end
    endtask

    task automatic test_infinite();
        req_t r;
        r = mk_req(1'b0, 1'b0, 32'hFFFF_FFFF, 16'd15, 32'd1, 16'd2, 32'd2);
        step(1'b0, 1'b1, r);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, r);
            n_tests++;
            if (bus.IDX_VALID !== 1'b1 || bus.IDX !== 16'(i % 16) || bus.SEGMENT !== 1'b0 ||
                bus.STOPPED !== 1'b0 || bus.IDX !== e_idx) begin
                n_fail++;
                $display("FAIL infinite %0d: valid/idx/seg/stop got %b/%0d/%b/%b want 1/%0d/0/0",
                         i, bus.IDX_VALID, bus.IDX, bus.SEGMENT, bus.STOPPED, i % 16);
            end
        end
    endtask

    task automatic test_immediate_switch();
        req_t r;
        int   seq [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
        r = mk_req(1'b1, 1'b0, 32'd0, 16'd15, 32'd1, 16'd3, 32'd3);
        step(1'b0, 1'b1, r);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, r);
            n_tests++;
            if (bus.IDX_VALID !== 1'b1 || bus.SEGMENT !== 1'b1 || bus.IDX !== 16'(seq[i]) || bus.STOPPED !== 1'b0) begin
                n_fail++;
                $display("FAIL imm_switch %0d: valid/idx/seg/stop got %b/%0d/%b/%b want 1/%0d/1/0",
                         i, bus.IDX_VALID, bus.IDX, bus.SEGMENT, bus.STOPPED, seq[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, r);
            n_tests++;
            if (bus.IDX_VALID !== 1'b1 || bus.IDX !== 16'd3 || bus.SEGMENT !== 1'b1 || bus.STOPPED !== 1'b1) begin
                n_fail++;
                $display("FAIL stopped %0d: valid/idx/seg/stop got %b/%0d/%b/%b want 1/3/1/1",
                         i, bus.IDX_VALID, bus.IDX, bus.SEGMENT, bus.STOPPED);
            end
        end
    endtask

    task automatic test_boundary_switch();
        req_t r0, r1;
        int   cnt;
        r0 = mk_req(1'b0, 1'b0, 32'hFFFF_FFFF, 16'd15, 32'd1, 16'd3, 32'd1);
        r1 = mk_req(1'b1, 1'b1, 32'hFFFF_FFFF, 16'd15, 32'd1, 16'd3, 32'd1);
        step(1'b0, 1'b1, r0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, r0);
        n_tests++;
        if (bus.IDX !== 16'd5 || bus.SEGMENT !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_setup: idx/seg got %0d/%b want 5/0", bus.IDX, bus.SEGMENT);
        end
        step(1'b0, 1'b1, r1);
        cnt = 0;
        while (bus.SEGMENT !== 1'b1 && cnt < 40) begin
            step(1'b1, 1'b0, r1);
            cnt++;
            n_tests++;
            if (bus.IDX !== e_idx || bus.SEGMENT !== e_seg || bus.IDX_VALID !== e_valid) begin
                n_fail++;
                $display("FAIL boundary_run %0d: idx/seg/valid got %0d/%b/%b want %0d/%b/%b",
                         cnt, bus.IDX, bus.SEGMENT, bus.IDX_VALID, e_idx, e_seg, e_valid);
            end
        end
        n_tests++;
        if (cnt != 11 || bus.IDX !== 16'd0 || bus.SEGMENT !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_switch: updates/idx/seg got %0d/%0d/%b want 11/0/1",
                     cnt, bus.IDX, bus.SEGMENT);
        end
    endtask

    task automatic test_last_wins();
        req_t ra, rb;
        int   cnt;
        // seg1 is running with CYCLE=3, FREQ_DIV=1, at IDX=0.
        ra = mk_req(1'b1, 1'b1, 32'hFFFF_FFFF, 16'd9, 32'd1, 16'd7, 32'd1);
        rb = mk_req(1'b0, 1'b1, 32'd1, 16'd5, 32'd2, 16'd7, 32'd1);
        step(1'b0, 1'b1, ra);
        step(1'b1, 1'b1, rb);
        n_tests++;
        if (bus.IDX !== 16'd1 || bus.SEGMENT !== 1'b1 || bus.IDX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle: idx/seg/valid got %0d/%b/%b want 1/1/1",
                     bus.IDX, bus.SEGMENT, bus.IDX_VALID);
        end
        cnt = 0;
        while (bus.SEGMENT !== 1'b0 && cnt < 10) begin
            step(1'b1, 1'b0, rb);
            cnt++;
        end
        n_tests++;
        if (cnt != 3 || bus.IDX !== 16'd0 || bus.SEGMENT !== 1'b0) begin
            n_fail++;
            $display("FAIL last_wins: updates/idx/seg got %0d/%0d/%b want 3/0/0", cnt, bus.IDX, bus.SEGMENT);
        end
        for (int i = 0; i < 28; i++) begin
            step(1'b1, 1'b0, rb);
            n_tests++;
            if (bus.IDX !== e_idx || bus.SEGMENT !== e_seg || bus.STOPPED !== e_stop || bus.IDX_VALID !== e_valid) begin
                n_fail++;
                $display("FAIL seg0_after %0d: idx/seg/stop/valid got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, bus.IDX, bus.SEGMENT, bus.STOPPED, bus.IDX_VALID, e_idx, e_seg, e_stop, e_valid);
            end
        end
    endtask

    task automatic test_cycle_zero();
        req_t r;
        r = mk_req(1'b1, 1'b0, 32'd2, 16'd4, 32'd1, 16'd0, 32'd0);
        step(1'b0, 1'b1, r);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, r);
            n_tests++;
            if (bus.IDX !== 16'd0 || bus.SEGMENT !== 1'b1 || bus.STOPPED !== (i >= 3) || bus.IDX_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL cycle_zero %0d: idx/seg/stop/valid got %0d/%b/%b/%b want 0/1/%b/1",
                         i, bus.IDX, bus.SEGMENT, bus.STOPPED, bus.IDX_VALID, i >= 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_t r;
        r = mk_req(1'b0, 1'b0, 32'hFFFF_FFFF, 16'd15, 32'd1, 16'd3, 32'd1);
        step(1'b0, 1'b1, r);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, r);
        n_tests++;
        if (bus.IDX !== 16'd7) begin
            n_fail++;
            $display("FAIL reset_mid_setup: idx got %0d want 7", bus.IDX);
        end
        step(1'b0, 1'b1, r);
        do_reset(1'b1);
        n_tests++;
        if (bus.IDX !== 16'd0 || bus.IDX_VALID !== 1'b0 || bus.SEGMENT !== 1'b0 || bus.STOPPED !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: idx/valid/seg/stop got %0d/%b/%b/%b want 0/0/0/0",
                     bus.IDX, bus.IDX_VALID, bus.SEGMENT, bus.STOPPED);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, r);
            n_tests++;
            if (bus.IDX_VALID !== 1'b0 || bus.IDX !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_mid_idle %0d: valid/idx got %b/%0d want 0/0", i, bus.IDX_VALID, bus.IDX);
            end
        end
    endtask

    task automatic test_random();
        req_t r;
        bit   upd, set;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 1));
            end else begin
                upd = ($urandom_range(0, 99) < 70);
                set = ($urandom_range(0, 99) < 8);
                r   = rand_req();
                step(upd, set, r);
            end
            n_tests++;
            if (bus.IDX_VALID !== e_valid || bus.IDX !== e_idx || bus.SEGMENT !== e_seg || bus.STOPPED !== e_stop) begin
                n_fail++;
                $display("FAIL random %0d: valid/idx/seg/stop got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         i, bus.IDX_VALID, bus.IDX, bus.SEGMENT, bus.STOPPED, e_valid, e_idx, e_seg, e_stop);
            end
        end
    endtask

    initial begin
        bus.UPDATE = 1'b0; bus.UPDATE_SETTINGS = 1'b0; bus.REQ_RD_SEGMENT = 1'b0;
        bus.REP = '0; bus.TRANSITION_MODE = 1'b0; bus.CYCLE_0 = '0; bus.CYCLE_1 = '0;
        bus.FREQ_DIV_0 = '0; bus.FREQ_DIV_1 = '0;
        m_reset();
        test_reset();
        test_infinite();
        test_immediate_switch();
        test_boundary_switch();
        test_last_wins();
        test_cycle_zero();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
